// File: rtl/execute_stage_if.sv
// Purpose: bundles the ID/EX inputs, forwarding inputs and EX/MEM outputs of the execute stage.
// Latency: wiring only, no state.
// Backpressure: stall_out travels upstream through this bundle, so the ID/EX side can hold its entry.
// Ports: master = ID/EX and hazard side (drives *_in, flush, Forward*), slave = execute_stage.
interface execute_stage_if;
    logic        flush;
    logic        Ctl_ALUSrc_in;
    logic [3:0]  ALU_ctl_in;
    logic        Ctl_MemtoReg_in, Ctl_RegWrite_in, Ctl_MemRead_in, Ctl_MemWrite_in;
    logic        Ctl_Branch_in, jal_in, jalr_in;
    logic [4:0]  Rd_in;
    logic [31:0] PC_in, Imm_in, Read_data1_in, Read_data2_in;
    logic [1:0]  ForwardA, ForwardB;
    logic [31:0] mem_fwd_data, wb_fwd_data;

    logic        Ctl_MemtoReg_out, Ctl_RegWrite_out, Ctl_MemRead_out, Ctl_MemWrite_out;
    logic        Ctl_Branch_out, jal_out, jalr_out, Zero_out;
    logic [4:0]  Rd_out;
    logic [31:0] ALUresult_out, Write_Data_out, PCimm_out, PC_out;
    logic        stall_out;

    modport master (
        output flush, Ctl_ALUSrc_in, ALU_ctl_in,
               Ctl_MemtoReg_in, Ctl_RegWrite_in, Ctl_MemRead_in, Ctl_MemWrite_in,
               Ctl_Branch_in, jal_in, jalr_in, Rd_in,
               PC_in, Imm_in, Read_data1_in, Read_data2_in,
               ForwardA, ForwardB, mem_fwd_data, wb_fwd_data,
        input  Ctl_MemtoReg_out, Ctl_RegWrite_out, Ctl_MemRead_out, Ctl_MemWrite_out,
               Ctl_Branch_out, jal_out, jalr_out, Zero_out, Rd_out,
               ALUresult_out, Write_Data_out, PCimm_out, PC_out, stall_out
    );

    modport slave (
        input  flush, Ctl_ALUSrc_in, ALU_ctl_in,
               Ctl_MemtoReg_in, Ctl_RegWrite_in, Ctl_MemRead_in, Ctl_MemWrite_in,
               Ctl_Branch_in, jal_in, jalr_in, Rd_in,
               PC_in, Imm_in, Read_data1_in, Read_data2_in,
               ForwardA, ForwardB, mem_fwd_data, wb_fwd_data,
        output Ctl_MemtoReg_out, Ctl_RegWrite_out, Ctl_MemRead_out, Ctl_MemWrite_out,
               Ctl_Branch_out, jal_out, jalr_out, Zero_out, Rd_out,
               ALUresult_out, Write_Data_out, PCimm_out, PC_out, stall_out
    );
endinterface

// File: rtl/execute_stage.sv
// Purpose: RV32-style execute stage: operand forwarding, ALU, EX/MEM pipeline register, optional iterative MUL.
// Latency: 1 cycle for ALU ops; MUL takes 34 cycles issue-to-capture with stall_out high for 33.
// Backpressure: stall_out (combinational) asks upstream to hold ID/EX; stalled cycles load bubbles into EX/MEM.
// Ports: clk, reset (async, active high), ex = execute_stage_if.slave.
// Build option: define EXECUTE_MUL_EN to include the shift-add multiplier; otherwise code 1010 yields 0.
module execute_stage (
    input  logic clk,
    input  logic reset,
    execute_stage_if.slave ex
);
    typedef struct packed {
        logic mem_to_reg;
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic branch;
        logic jal;
        logic jalr;
    } ctl_t;

    logic [31:0] op_a, fwd_b, op_b, alu_res;
    logic        stall, load_bubble;
    ctl_t        ctl_in, ctl_q;
    logic [4:0]  rd_q;
    logic [31:0] res_q, wdata_q, pcimm_q, pc_q;
    logic        zero_q;

    assign ctl_in = '{mem_to_reg: ex.Ctl_MemtoReg_in, reg_write: ex.Ctl_RegWrite_in,
                      mem_read: ex.Ctl_MemRead_in, mem_write: ex.Ctl_MemWrite_in,
                      branch: ex.Ctl_Branch_in, jal: ex.jal_in, jalr: ex.jalr_in};

    always_comb begin
        case (ex.ForwardA)
            2'b10:   op_a = ex.mem_fwd_data;
            2'b01:   op_a = ex.wb_fwd_data;
            default: op_a = ex.Read_data1_in;
        endcase
        case (ex.ForwardB)
            2'b10:   fwd_b = ex.mem_fwd_data;
            2'b01:   fwd_b = ex.wb_fwd_data;
            default: fwd_b = ex.Read_data2_in;
        endcase
        op_b = ex.Ctl_ALUSrc_in ? ex.Imm_in : fwd_b;
    end

    // MUL (1010) deliberately falls to the default: its single-cycle result is 0,
    // and the real product comes from the iterative unit when it is built in.
    always_comb begin
        alu_res = '0;
        case (ex.ALU_ctl_in)
            4'b0000: alu_res = op_a & op_b;
            4'b0001: alu_res = op_a | op_b;
            4'b0010: alu_res = op_a + op_b;
            4'b0110: alu_res = op_a - op_b;
            4'b0111: alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
            4'b1000: alu_res = {31'd0, op_a < op_b};
            4'b1001: alu_res = op_a ^ op_b;
            4'b0011: alu_res = op_a << op_b[4:0];
            4'b0100: alu_res = op_a >> op_b[4:0];
            4'b0101: alu_res = $signed(op_a) >>> op_b[4:0];
            default: alu_res = '0;
        endcase
    end

`ifdef EXECUTE_MUL_EN
    localparam logic [3:0] ALU_MUL = 4'b1010;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_t;

    mul_state_t  state;
    logic [4:0]  cnt;
    logic [31:0] mcand, mplier, prod;
    // Everything the EX/MEM register needs at capture time, frozen at issue.
    ctl_t        h_ctl;
    logic [4:0]  h_rd;
    logic [31:0] h_wdata, h_pcimm, h_pc;
    logic        capture_mul;

    assign stall = !reset && !ex.flush &&
                   ((state == BUSY) || (state == IDLE && ex.ALU_ctl_in == ALU_MUL));
    assign capture_mul = (state == DONE) && !ex.flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            prod    <= '0;
            h_ctl   <= '0;
            h_rd    <= '0;
            h_wdata <= '0;
            h_pcimm <= '0;
            h_pc    <= '0;
        end else if (ex.flush) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: if (ex.ALU_ctl_in == ALU_MUL) begin
                    mcand   <= op_a;
                    mplier  <= op_b;
                    prod    <= '0;
                    cnt     <= '0;
                    h_ctl   <= ctl_in;
                    h_rd    <= ex.Rd_in;
                    h_wdata <= fwd_b;
                    h_pcimm <= ex.PC_in + ex.Imm_in;
                    h_pc    <= ex.PC_in;
                    state   <= BUSY;
                end
                BUSY: begin
                    // One multiplier bit per cycle; bits shifted past 31 are dropped.
                    if (mplier[0]) prod <= prod + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 5'd1;
                    if (cnt == 5'd31) state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    assign stall = 1'b0;
`endif

    assign load_bubble = ex.flush | stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctl_q   <= '0;
            rd_q    <= '0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            wdata_q <= '0;
            pcimm_q <= '0;
            pc_q    <= '0;
        end else begin
`ifdef EXECUTE_MUL_EN
            if (capture_mul) begin
                ctl_q   <= h_ctl;
                rd_q    <= h_rd;
                res_q   <= prod;
                zero_q  <= (prod == 32'd0);
                wdata_q <= h_wdata;
                pcimm_q <= h_pcimm;
                pc_q    <= h_pc;
            end else
`endif
            begin
                ctl_q   <= load_bubble ? ctl_t'('0) : ctl_in;
                rd_q    <= ex.Rd_in;
                res_q   <= alu_res;
                zero_q  <= (alu_res == 32'd0);
                wdata_q <= fwd_b;
                pcimm_q <= ex.PC_in + ex.Imm_in;
                pc_q    <= ex.PC_in;
            end
        end
    end

    assign ex.Ctl_MemtoReg_out = ctl_q.mem_to_reg;
    assign ex.Ctl_RegWrite_out = ctl_q.reg_write;
    assign ex.Ctl_MemRead_out  = ctl_q.mem_read;
    assign ex.Ctl_MemWrite_out = ctl_q.mem_write;
    assign ex.Ctl_Branch_out   = ctl_q.branch;
    assign ex.jal_out          = ctl_q.jal;
    assign ex.jalr_out         = ctl_q.jalr;
    assign ex.Zero_out         = zero_q;
    assign ex.Rd_out           = rd_q;
    assign ex.ALUresult_out    = res_q;
    assign ex.Write_Data_out   = wdata_q;
    assign ex.PCimm_out        = pcimm_q;
    assign ex.PC_out           = pc_q;
    assign ex.stall_out        = stall;
endmodule
